// File: rtl/vga_tile_scanner.sv
// vga_tile_scanner: VGA raster timing generator with tile-grid addressing.
// Drives sync, active-video, tile cell / in-tile offset, line and frame
// strobes, and a game tick every TICK_FRAMES frames.
//
// Ports:
//   i_Clk          pixel clock
//   i_Reset        synchronous reset, active-high
//   o_HSync        horizontal sync (polarity from SYNC_NEG)
//   o_VSync        vertical sync (polarity from SYNC_NEG)
//   o_Active       pixel inside the visible H_DISPLAY x V_DISPLAY window
//   o_Cell_Valid   o_Active and pixel inside the tile grid
//   o_Cell_X       tile column (0 outside the grid)
//   o_Cell_Y       tile row (0 outside the grid)
//   o_Tile_Px      x offset inside the tile (0 outside the grid)
//   o_Tile_Py      y offset inside the tile (0 outside the grid)
//   o_Line_Start   1-clk pulse for h = 0
//   o_Frame_Start  1-clk pulse for h = 0, v = 0
//   o_Game_Tick    1-clk pulse on every TICK_FRAMES-th frame start
//
// All outputs are registered and describe the counter state of the
// previous clock.

module vga_tile_scanner #(
    parameter int H_SYNC      = 92,
    parameter int H_BACK      = 50,
    parameter int H_DISPLAY   = 640,
    parameter int H_FRONT     = 18,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int V_DISPLAY   = 480,
    parameter int V_FRONT     = 10,
    parameter int TILE_W      = 32,
    parameter int TILE_H      = 32,
    parameter int GRID_W      = 20,
    parameter int GRID_H      = 15,
    parameter int SYNC_NEG    = 1,
    parameter int TICK_FRAMES = 1
) (
    input  logic                      i_Clk,
    input  logic                      i_Reset,
    output logic                      o_HSync,
    output logic                      o_VSync,
    output logic                      o_Active,
    output logic                      o_Cell_Valid,
    output logic [$clog2(GRID_W)-1:0] o_Cell_X,
    output logic [$clog2(GRID_H)-1:0] o_Cell_Y,
    output logic [$clog2(TILE_W)-1:0] o_Tile_Px,
    output logic [$clog2(TILE_H)-1:0] o_Tile_Py,
    output logic                      o_Line_Start,
    output logic                      o_Frame_Start,
    output logic                      o_Game_Tick
);

    // ------------------------------------------------------------------
    // Derived geometry
    // ------------------------------------------------------------------
    localparam int H_TOT   = H_SYNC + H_BACK + H_DISPLAY + H_FRONT;
    localparam int V_TOT   = V_SYNC + V_BACK + V_DISPLAY + V_FRONT;
    localparam int H_ACT_S = H_SYNC + H_BACK;
    localparam int H_ACT_E = H_ACT_S + H_DISPLAY;
    localparam int V_ACT_S = V_SYNC + V_BACK;
    localparam int V_ACT_E = V_ACT_S + V_DISPLAY;

    // +1 keeps the exclusive end bounds representable even when a total
    // happens to be an exact power of two.
    localparam int HW = $clog2(H_TOT + 1);
    localparam int VW = $clog2(V_TOT + 1);

    // Cell counters run across the whole visible width/height (not only
    // the grid) so the grid bound can be tested without a multiplier.
    localparam int CXW = $clog2(H_DISPLAY / TILE_W + 2);
    localparam int CYW = $clog2(V_DISPLAY / TILE_H + 2);
    localparam int CXO = $clog2(GRID_W);
    localparam int CYO = $clog2(GRID_H);
    localparam int PXW = $clog2(TILE_W);
    localparam int PYW = $clog2(TILE_H);
    localparam int FW  = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;

    localparam logic [HW-1:0]  H_LAST   = HW'(H_TOT - 1);
    localparam logic [VW-1:0]  V_LAST   = VW'(V_TOT - 1);
    localparam logic [HW-1:0]  H_SYNC_E = HW'(H_SYNC);
    localparam logic [VW-1:0]  V_SYNC_E = VW'(V_SYNC);
    localparam logic [HW-1:0]  H_A_S    = HW'(H_ACT_S);
    localparam logic [HW-1:0]  H_A_E    = HW'(H_ACT_E);
    localparam logic [VW-1:0]  V_A_S    = VW'(V_ACT_S);
    localparam logic [VW-1:0]  V_A_E    = VW'(V_ACT_E);
    localparam logic [PXW-1:0] PX_LAST  = PXW'(TILE_W - 1);
    localparam logic [PYW-1:0] PY_LAST  = PYW'(TILE_H - 1);
    localparam logic [CXW-1:0] CX_LIM   = CXW'(GRID_W);
    localparam logic [CYW-1:0] CY_LIM   = CYW'(GRID_H);
    localparam logic [FW-1:0]  FR_LAST  = FW'(TICK_FRAMES - 1);

    // Idle level of the sync lines.
    localparam logic SYNC_IDLE = (SYNC_NEG != 0);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [HW-1:0]  h;
    logic [VW-1:0]  v;
    logic [PXW-1:0] px;
    logic [CXW-1:0] cx;
    logic [PYW-1:0] py;
    logic [CYW-1:0] cy;
    logic [FW-1:0]  frame_cnt;

    // ------------------------------------------------------------------
    // Decode of the current counter state
    // ------------------------------------------------------------------
    logic h_wrap;
    logic v_wrap;
    logic h_act;
    logic v_act;
    logic in_grid;
    logic cell_ok;
    logic frame_edge;

    always_comb begin
        h_wrap     = (h == H_LAST);
        v_wrap     = (v == V_LAST);
        h_act      = (h >= H_A_S) && (h < H_A_E);
        v_act      = (v >= V_A_S) && (v < V_A_E);
        in_grid    = (cx < CX_LIM) && (cy < CY_LIM);
        cell_ok    = h_act && v_act && in_grid;
        frame_edge = (h == '0) && (v == '0);
    end

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            h <= '0;
            v <= '0;
        end else if (h_wrap) begin
            h <= '0;
            v <= v_wrap ? '0 : v + VW'(1);
        end else begin
            h <= h + HW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Horizontal tile tracking
    // Held at 0 through blanking so the first visible pixel of every
    // line starts at column 0, offset 0.
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            px <= '0;
            cx <= '0;
        end else if (h_act) begin
            if (px == PX_LAST) begin
                px <= '0;
                cx <= cx + CXW'(1);
            end else begin
                px <= px + PXW'(1);
            end
        end else begin
            px <= '0;
            cx <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Vertical tile tracking
    // Advances at the end of each visible line; cleared at the end of
    // every blanking line so the first visible line starts at row 0.
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            py <= '0;
            cy <= '0;
        end else if (h_wrap) begin
            if (v_act) begin
                if (py == PY_LAST) begin
                    py <= '0;
                    cy <= cy + CYW'(1);
                end else begin
                    py <= py + PYW'(1);
                end
            end else begin
                py <= '0;
                cy <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame counter for the game tick. A tick goes with the frame start
    // seen while the counter sits at 0, so the first frame after reset
    // always ticks.
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            frame_cnt <= '0;
        end else if (frame_edge) begin
            frame_cnt <= (frame_cnt == FR_LAST) ? '0 : frame_cnt + FW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_HSync       <= SYNC_IDLE;
            o_VSync       <= SYNC_IDLE;
            o_Active      <= 1'b0;
            o_Cell_Valid  <= 1'b0;
            o_Cell_X      <= '0;
            o_Cell_Y      <= '0;
            o_Tile_Px     <= '0;
            o_Tile_Py     <= '0;
            o_Line_Start  <= 1'b0;
            o_Frame_Start <= 1'b0;
            o_Game_Tick   <= 1'b0;
        end else begin
            o_HSync       <= (h < H_SYNC_E) ? ~SYNC_IDLE : SYNC_IDLE;
            o_VSync       <= (v < V_SYNC_E) ? ~SYNC_IDLE : SYNC_IDLE;
            o_Active      <= h_act && v_act;
            o_Cell_Valid  <= cell_ok;
            o_Cell_X      <= cell_ok ? cx[CXO-1:0] : '0;
            o_Cell_Y      <= cell_ok ? cy[CYO-1:0] : '0;
            o_Tile_Px     <= cell_ok ? px : '0;
            o_Tile_Py     <= cell_ok ? py : '0;
            o_Line_Start  <= (h == '0);
            o_Frame_Start <= frame_edge;
            o_Game_Tick   <= frame_edge && (frame_cnt == '0);
        end
    end

endmodule

// File: tb/tb_vga_tile_scanner.sv
// tb_vga_tile_scanner: scoreboard bench for vga_tile_scanner using a
// scaled-down raster, a partial tile grid and a 3-frame game tick.

module tb_vga_tile_scanner;

    localparam int HS = 4;
    localparam int HB = 3;
    localparam int HD = 40;
    localparam int HF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int VD = 24;
    localparam int VF = 2;
    localparam int TW = 8;
    localparam int TH = 4;
    localparam int GW = 4;
    localparam int GH = 5;
    localparam int SN = 1;
    localparam int TF = 3;

    localparam int HT    = HS + HB + HD + HF;
    localparam int VT    = VS + VB + VD + VF;
    localparam int FRAME = HT * VT;

    localparam int CXO = $clog2(GW);
    localparam int CYO = $clog2(GH);
    localparam int PXW = $clog2(TW);
    localparam int PYW = $clog2(TH);

    localparam int NCYC       = 22000;
    localparam int CLEAN_END  = 3 + 7 * FRAME + 10;
    localparam int DIRECT_RST = 11000;
    localparam int RAND_START = 11600;

    typedef struct packed {
        logic           hs;
        logic           vs;
        logic           act;
        logic           cv;
        logic [CXO-1:0] cx;
        logic [CYO-1:0] cy;
        logic [PXW-1:0] px;
        logic [PYW-1:0] py;
        logic           ls;
        logic           fs;
        logic           gt;
    } exp_t;

    logic           clk;
    logic           rst;
    logic           hsync;
    logic           vsync;
    logic           active;
    logic           cell_valid;
    logic [CXO-1:0] cell_x;
    logic [CYO-1:0] cell_y;
    logic [PXW-1:0] tile_px;
    logic [PYW-1:0] tile_py;
    logic           line_start;
    logic           frame_start;
    logic           game_tick;

    exp_t sb[$];
    int   checks;
    int   errors;
    int   cyc;

    vga_tile_scanner #(
        .H_SYNC(HS), .H_BACK(HB), .H_DISPLAY(HD), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_DISPLAY(VD), .V_FRONT(VF),
        .TILE_W(TW), .TILE_H(TH), .GRID_W(GW), .GRID_H(GH),
        .SYNC_NEG(SN), .TICK_FRAMES(TF)
    ) dut (
        .i_Clk        (clk),
        .i_Reset      (rst),
        .o_HSync      (hsync),
        .o_VSync      (vsync),
        .o_Active     (active),
        .o_Cell_Valid (cell_valid),
        .o_Cell_X     (cell_x),
        .o_Cell_Y     (cell_y),
        .o_Tile_Px    (tile_px),
        .o_Tile_Py    (tile_py),
        .o_Line_Start (line_start),
        .o_Frame_Start(frame_start),
        .o_Game_Tick  (game_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic sync_lvl(bit asserted);
        return asserted ? (SN == 0) : (SN != 0);
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e    = '0;
        e.hs = sync_lvl(1'b0);
        e.vs = sync_lvl(1'b0);
        return e;
    endfunction

    // Outputs expected for the n-th cycle since reset release, from
    // plain position arithmetic on the raster.
    function automatic exp_t model(int n);
        exp_t e;
        int h, v, fr, x, y;
        h  = n % HT;
        v  = (n / HT) % VT;
        fr = n / FRAME;
        x  = h - (HS + HB);
        y  = v - (VS + VB);
        e     = '0;
        e.hs  = sync_lvl(h < HS);
        e.vs  = sync_lvl(v < VS);
        e.act = (x >= 0) && (x < HD) && (y >= 0) && (y < VD);
        e.cv  = e.act && (x < GW * TW) && (y < GH * TH);
        if (e.cv) begin
            e.cx = CXO'(x / TW);
            e.cy = CYO'(y / TH);
            e.px = PXW'(x % TW);
            e.py = PYW'(y % TH);
        end
        e.ls = (h == 0);
        e.fs = (h == 0) && (v == 0);
        e.gt = e.fs && (fr % TF == 0);
        return e;
    endfunction

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            if (errors <= 20)
                $display("FAIL %s cycle %0d: got %0d, expected %0d",
                         name, cyc, act, req);
        end
    endtask

    // Stimulus: drives reset at the falling edge and pushes the
    // expected response for the next rising edge.
    initial begin : stim
        exp_t e;
        int   n;
        int   rst_left;
        bit   r;
        n        = 0;
        rst_left = 0;
        rst      = 1'b1;
        for (int c = 0; c < NCYC; c++) begin
            if (c < 3) begin
                r = 1'b1;
            end else if (c == DIRECT_RST) begin
                r = 1'b1;
            end else if (c >= RAND_START) begin
                if (rst_left == 0 && $urandom_range(0, 2999) == 0)
                    rst_left = $urandom_range(1, 3);
                r = (rst_left > 0);
                if (rst_left > 0)
                    rst_left--;
            end else begin
                r = 1'b0;
            end
            rst = r;
            if (r) begin
                e = reset_exp();
                n = 0;
            end else begin
                e = model(n);
                n++;
            end
            sb.push_back(e);
            @(negedge clk);
        end
        rst = 1'b0;
    end

    // Monitor: one DUT output set per rising edge.
    initial begin : mon
        exp_t e;
        checks = 0;
        errors = 0;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            if (sb.size() == 0) begin
                check("scoreboard_empty", 1, 0);
            end else begin
                e = sb.pop_front();
                check("hsync",       int'(hsync),       int'(e.hs));
                check("vsync",       int'(vsync),       int'(e.vs));
                check("active",      int'(active),      int'(e.act));
                check("cell_valid",  int'(cell_valid),  int'(e.cv));
                check("cell_x",      int'(cell_x),      int'(e.cx));
                check("cell_y",      int'(cell_y),      int'(e.cy));
                check("tile_px",     int'(tile_px),     int'(e.px));
                check("tile_py",     int'(tile_py),     int'(e.py));
                check("line_start",  int'(line_start),  int'(e.ls));
                check("frame_start", int'(frame_start), int'(e.fs));
                check("game_tick",   int'(game_tick),   int'(e.gt));
            end
        end
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin : watchdog
        #((NCYC + 100) * 10 * 2);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
